display_mode_sequencer: RTL
===========================

Name: display_mode_sequencer

Overview:
Parametrised top-level mode sequencer and display multiplexer for the board clock design. It accepts NUM_MODES display sources, each of NUM_DIGITS seven-segment digits plus an LED bank. Two debounced push-buttons step the active mode forward or backward with wrap-around, and the block drives one-hot enables to the function blocks. Unlike the earlier mode switcher, it runs on the system clock rather than a derived pulse, has a proper reset, debounces the buttons, supports bidirectional stepping, and blanks the display briefly on every mode change.

Parameters:
NUM_MODES, 4, number of selectable sources (2..16)
NUM_DIGITS, 4, seven-segment digits per source
SEG_W, 7, bits per digit
LED_W, 10, LED bank width
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles before a button level is accepted (10 ms at 50 MHz)
BLANK_CYCLES, 5000000, cycles the display stays blank after a mode change (0 = no blanking)
SEG_OFF, 7'b1111111, digit pattern for "all segments off" (segments are active-low)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
btn_next_n  in  1  raw push-button, active-low, asynchronous to clk
btn_prev_n  in  1  raw push-button, active-low, asynchronous to clk
seg_in  in  NUM_MODES*NUM_DIGITS*SEG_W  source m, digit d at offset (m*NUM_DIGITS+d)*SEG_W; digit 0 is the rightmost display
led_in  in  NUM_MODES*LED_W  source m LED bank at offset m*LED_W
seg_out  out  NUM_DIGITS*SEG_W  registered digit patterns
led_out  out  LED_W  registered LED bank
mode_enable  out  NUM_MODES  one-hot enable, bit m set while mode m is active
mode_idx  out  $clog2(NUM_MODES)  current mode index
mode_changed  out  1  single-cycle pulse on the cycle mode_idx updates

Behaviour:
- Reset (reset=0, async): mode_idx=0; mode_enable=1 (bit 0 set); seg_out = SEG_OFF on every digit; led_out=0; mode_changed=0; debounced levels=1 (released); debounce and blank counters=0.
- Button path, per button:
  - 2-FF synchroniser feeds a debouncer.
  - Debounce counter resets whenever the synchronised level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level takes the new value.
  - A press event is a one-cycle strobe on the debounced 1->0 transition. Release generates no event.
- Mode update, on the cycle after the strobe:
  - next only: mode_idx = (mode_idx==NUM_MODES-1) ? 0 : mode_idx+1.
  - prev only: mode_idx = (mode_idx==0) ? NUM_MODES-1 : mode_idx-1.
  - next and prev strobes in the same cycle: both ignored; no change and no pulse.
  - mode_enable and mode_changed update in the same cycle as mode_idx.
- Press timing: a press held stable produces exactly one step. Latency from pin edge to mode_idx change = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. Bounces shorter than DEBOUNCE_CYCLES produce no step.
- Display state machine:
  - States: SHOW and BLANK.
  - SHOW -> BLANK on mode_changed when BLANK_CYCLES>0. The blank counter loads BLANK_CYCLES-1.
  - BLANK -> SHOW when the counter reaches 0.
  - A mode change while in BLANK reloads the counter and stays in BLANK.
  - In BLANK: seg_out = SEG_OFF on all digits, led_out=0.
  - In SHOW: seg_out and led_out are registered copies of the selected source, with 1-cycle latency from seg_in/led_in.
- Width rule: MODE_W=$clog2(NUM_MODES), minimum 1. Indices >= NUM_MODES are unreachable; if ever present, the outputs are SEG_OFF/0.
- Reset asserted mid-debounce or mid-blank aborts immediately to the reset values.

Optional Feature:
MODE_INDICATOR_EN:
- Defined: in SHOW, led_out[LED_W-1 -: NUM_MODES] is overridden with mode_enable, and the lower bits come from the source. Requires LED_W >= NUM_MODES, checked with an elaboration-time error. In BLANK, led_out shows only mode_enable in the top bits.
- Undefined: led_out is exactly as specified under Behaviour.

Decomposition:
- Shared package display_pkg: SEG_OFF, SEG_W, default NUM_DIGITS/LED_W, and a function clog2_min1.
- Sub-module button_debounce (synchroniser, debounce counter, press strobe; parameter DEBOUNCE_CYCLES), instantiated twice.

Test Plan:
- Reset, then release: mode_idx=0, mode_enable=4'b0001, seg_out all 7'h7F during the blank-free start, then source 0 patterns after 1 cycle.
- Run with DEBOUNCE_CYCLES=8, BLANK_CYCLES=4. Hold btn_next_n low for 20 cycles -> exactly one step 0->1, mode_changed high for 1 cycle, 4 blank cycles, then seg_out = source 1.
- Four next presses from mode 3 -> sequence 3,0,1,2,3 (wrap); one prev press from 0 -> 3.
- 5-cycle glitch low on btn_prev_n -> no mode change and no pulse.
- Both buttons pressed in the same cycle (stable 20 cycles) -> no change; a second next press during BLANK -> counter reloads, blank lasts 4 cycles after the second change.
- Assert reset during BLANK at mode 2 -> outputs return to reset values asynchronously; with MODE_INDICATOR_EN, mode 2 drives led_out[9:6]=4'b0100.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, display FSM state type and width helper for the
// display mode sequencer slice.
package display_pkg;

  localparam int unsigned DISP_SEG_W      = 7;
  localparam logic [DISP_SEG_W-1:0] DISP_SEG_OFF = 7'b1111111;
  localparam int unsigned DISP_NUM_DIGITS = 4;
  localparam int unsigned DISP_LED_W      = 10;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } disp_state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and a
// one-cycle press strobe on the accepted released->pressed transition.
module button_debounce
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync2 != level) && (cnt == CNT_LAST);

  // Bring the raw pin into the clk domain; idles at released (1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= accept && !sync2;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_mode_sequencer.sv
// Mode sequencer and display multiplexer: two debounced buttons step the
// active source forward/backward with wrap, the display blanks briefly on
// every change. Optional macro MODE_INDICATOR_EN overlays the one-hot mode
// enable onto the top LED bits.
module display_mode_sequencer
  import display_pkg::*;
#(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned NUM_DIGITS      = DISP_NUM_DIGITS,
  parameter int unsigned SEG_W           = DISP_SEG_W,
  parameter int unsigned LED_W           = DISP_LED_W,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLANK_CYCLES    = 5000000,
  parameter logic [SEG_W-1:0] SEG_OFF    = SEG_W'(DISP_SEG_OFF),
  localparam int unsigned MODE_W         = clog2_min1(NUM_MODES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               btn_next_n,
  input  logic                               btn_prev_n,
  input  logic [NUM_MODES*NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_MODES*LED_W-1:0]         led_in,
  output logic [NUM_DIGITS*SEG_W-1:0]        seg_out,
  output logic [LED_W-1:0]                   led_out,
  output logic [NUM_MODES-1:0]               mode_enable,
  output logic [MODE_W-1:0]                  mode_idx,
  output logic                               mode_changed
);

  localparam int unsigned BLANK_W = clog2_min1(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_LOAD =
    (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam int unsigned SRC_W = NUM_DIGITS * SEG_W;

  if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_bad_modes
    $error("NUM_MODES must be in 2..16");
  end

`ifdef MODE_INDICATOR_EN
  if (LED_W < NUM_MODES) begin : g_bad_led_w
    $error("MODE_INDICATOR_EN needs LED_W >= NUM_MODES");
  end
`endif

  logic              next_p;
  logic              prev_p;
  logic              step;
  logic [MODE_W-1:0] idx_next;

  disp_state_t        state;
  disp_state_t        state_next;
  logic [BLANK_W-1:0] blank_cnt;
  logic [BLANK_W-1:0] blank_cnt_next;

  logic [SRC_W-1:0] sel_seg;
  logic [LED_W-1:0] sel_led;
  logic [SRC_W-1:0] seg_next;
  logic [LED_W-1:0] led_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_next_n),
    .press (next_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_prev (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_prev_n),
    .press (prev_p)
  );

  // Next mode index with wrap; simultaneous strobes cancel each other.
  always_comb begin
    step     = next_p ^ prev_p;
    idx_next = mode_idx;
    if (next_p && !prev_p) begin
      idx_next = (mode_idx == MODE_LAST) ? '0 : mode_idx + 1'b1;
    end else if (prev_p && !next_p) begin
      idx_next = (mode_idx == '0) ? MODE_LAST : mode_idx - 1'b1;
    end
  end

  // Mode register, one-hot enable and change pulse update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_idx     <= '0;
      mode_enable  <= NUM_MODES'(1);
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= step;
      if (step) begin
        mode_idx    <= idx_next;
        mode_enable <= NUM_MODES'(1) << idx_next;
      end
    end
  end

  // Blank/show state and blank counter transitions.
  always_comb begin
    state_next     = state;
    blank_cnt_next = blank_cnt;
    case (state)
      SHOW: begin
        if (mode_changed && BLANK_CYCLES != 0) begin
          state_next     = BLANK;
          blank_cnt_next = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (mode_changed) begin
          blank_cnt_next = BLANK_LOAD;
        end else if (blank_cnt == '0) begin
          state_next = SHOW;
        end else begin
          blank_cnt_next = blank_cnt - 1'b1;
        end
      end
      default: begin
        state_next     = SHOW;
        blank_cnt_next = '0;
      end
    endcase
  end

  // Select the active source; an out-of-range index shows nothing.
  always_comb begin
    sel_seg = {NUM_DIGITS{SEG_OFF}};
    sel_led = '0;
    for (int unsigned m = 0; m < NUM_MODES; m++) begin
      if (mode_idx == MODE_W'(m)) begin
        sel_seg = seg_in[m*SRC_W +: SRC_W];
        sel_led = led_in[m*LED_W +: LED_W];
      end
    end
  end

  // Output data decided from the upcoming state so blanking and the
  // register contents stay aligned to the state register.
  always_comb begin
    if (state_next == BLANK) begin
      seg_next = {NUM_DIGITS{SEG_OFF}};
      led_next = '0;
    end else begin
      seg_next = sel_seg;
      led_next = sel_led;
    end
`ifdef MODE_INDICATOR_EN
    led_next[LED_W-1 -: NUM_MODES] = mode_enable;
`else
    led_next = led_next;
`endif
  end

  // Display state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SHOW;
      blank_cnt <= '0;
      seg_out   <= {NUM_DIGITS{SEG_OFF}};
      led_out   <= '0;
    end else begin
      state     <= state_next;
      blank_cnt <= blank_cnt_next;
      seg_out   <= seg_next;
      led_out   <= led_next;
    end
  end

endmodule
